// File: rtl/calc_pkg.sv
// Shared types, ASCII constants and the keypad layout for the calculator.
package calc_pkg;

    typedef enum logic [1:0] {S_A, S_B, S_CALC, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

    localparam logic [7:0] CH_NONE  = 8'h00;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CLR   = 8'h43;

    // Button character at (row, col); the blank cell returns CH_NONE.
    function automatic logic [7:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [7:0] ch;
        case ({row, col})
            4'h0: ch = 8'h31;
            4'h1: ch = 8'h32;
            4'h2: ch = 8'h33;
            4'h3: ch = CH_PLUS;
            4'h4: ch = 8'h34;
            4'h5: ch = 8'h35;
            4'h6: ch = 8'h36;
            4'h7: ch = CH_MINUS;
            4'h8: ch = 8'h37;
            4'h9: ch = 8'h38;
            4'hA: ch = 8'h39;
            4'hB: ch = CH_STAR;
            4'hC: ch = CH_CLR;
            4'hD: ch = CH_0;
            4'hE: ch = CH_EQ;
            default: ch = CH_NONE;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/calc_mul.sv
// Start/done shift-add multiplier; done and product are presented combinationally on the last step.
module calc_mul
    import calc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk_in,
    input  logic           sys_rst_n,
    input  logic           i_clr,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done_c,
    output logic [2*W-1:0] o_product_c
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [PW-1:0]    r_mcand;
    logic [W-1:0]     r_mplier;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [PW-1:0]    w_acc_next;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done_c    = r_busy && (r_cnt == CNT_W'(W - 1));
    assign o_product_c = w_acc_next;

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_clr) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= PW'(i_a);
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_done_c) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: keypad cursor, operand entry, operator selection and result.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned OPERAND_W = 8
) (
    input  logic                   clk_in,
    input  logic                   sys_rst_n,
    input  logic                   key_up,
    input  logic                   key_down,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   key_sel,
    output logic [3:0]             cursor_x,
    output logic [3:0]             cursor_y,
    output logic [7:0]             input_val,
    output logic [7:0]             op_char,
    output logic [2*OPERAND_W-1:0] result,
    output logic                   calc_done,
    output logic                   busy
);

    localparam int unsigned RES_W = 2 * OPERAND_W;
    localparam int unsigned ACC_W = OPERAND_W + 4;

    state_t               r_state;
    op_t                  r_op;
    logic [1:0]           r_cur_x;
    logic [1:0]           r_cur_y;
    logic [OPERAND_W-1:0] r_a;
    logic [OPERAND_W-1:0] r_b;

    logic [7:0]           w_key;
    logic [3:0]           w_digit;
    logic                 w_is_digit;
    logic                 w_is_op;
    logic                 w_is_eq;
    logic                 w_is_clr;
    op_t                  w_op;
    logic [OPERAND_W-1:0] w_acc_sel;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_fits;
    logic                 w_start;
    logic                 w_mul_done;
    logic [RES_W-1:0]     w_mul_prod;
    logic [RES_W-1:0]     w_sum;
    logic [RES_W-1:0]     w_diff;

    assign w_key      = key_at(r_cur_y, r_cur_x);
    assign w_digit    = 4'(w_key - CH_0);
    assign w_is_digit = key_sel && (w_key >= CH_0) && (w_key <= CH_9);
    assign w_is_op    = key_sel && ((w_key == CH_PLUS) || (w_key == CH_MINUS) || (w_key == CH_STAR));
    assign w_is_eq    = key_sel && (w_key == CH_EQ);
    assign w_is_clr   = key_sel && (w_key == CH_CLR);

    always_comb begin
        w_op = OP_NONE;
        case (w_key)
            CH_PLUS:  w_op = OP_ADD;
            CH_MINUS: w_op = OP_SUB;
            CH_STAR:  w_op = OP_MUL;
            default:  w_op = OP_NONE;
        endcase
    end

    // Digit accumulation is dropped when the new value would not fit the operand.
    assign w_acc_sel  = (r_state == S_A) ? r_a : r_b;
    assign w_acc_next = ACC_W'(w_acc_sel) * ACC_W'(10) + ACC_W'(w_digit);
    assign w_fits     = (w_acc_next[ACC_W-1:OPERAND_W] == '0);

    assign w_sum   = RES_W'(r_a) + RES_W'(r_b);
    assign w_diff  = (r_a >= r_b) ? RES_W'(r_a - r_b) : '0;
    assign w_start = (r_state == S_B) && w_is_eq && (r_op == OP_MUL);

    assign cursor_x = {2'b00, r_cur_x};
    assign cursor_y = {2'b00, r_cur_y};

    calc_mul #(.W(OPERAND_W)) u_mul (
        .clk_in      (clk_in),
        .sys_rst_n   (sys_rst_n),
        .i_clr       (w_is_clr),
        .i_start     (w_start),
        .i_a         (r_a),
        .i_b         (r_b),
        .o_done_c    (w_mul_done),
        .o_product_c (w_mul_prod)
    );

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_A;
            r_op      <= OP_NONE;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            input_val <= CH_NONE;
            op_char   <= CH_NONE;
            result    <= '0;
            calc_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (key_up)         r_cur_y <= r_cur_y - 2'd1;
            else if (key_down)  r_cur_y <= r_cur_y + 2'd1;
            else if (key_left)  r_cur_x <= r_cur_x - 2'd1;
            else if (key_right) r_cur_x <= r_cur_x + 2'd1;

            if (w_is_clr) begin
                r_state   <= S_A;
                r_op      <= OP_NONE;
                r_a       <= '0;
                r_b       <= '0;
                input_val <= CH_NONE;
                op_char   <= CH_NONE;
                result    <= '0;
                calc_done <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_is_digit) begin
                            input_val <= w_key;
                            if (w_fits) r_a <= OPERAND_W'(w_acc_next);
                        end else if (w_is_op) begin
                            r_op    <= w_op;
                            op_char <= w_key;
                            r_state <= S_B;
                        end
                    end
                    S_B: begin
                        if (w_is_digit) begin
                            input_val <= w_key;
                            if (w_fits) r_b <= OPERAND_W'(w_acc_next);
                        end else if (w_is_op) begin
                            r_op    <= w_op;
                            op_char <= w_key;
                        end else if (w_is_eq) begin
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        if (r_op == OP_MUL) begin
                            if (w_mul_done) begin
                                result    <= w_mul_prod;
                                calc_done <= 1'b1;
                                busy      <= 1'b0;
                                r_state   <= S_DONE;
                            end
                        end else begin
                            result    <= (r_op == OP_SUB) ? w_diff : w_sum;
                            calc_done <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (w_is_digit) begin
                            r_a       <= OPERAND_W'(w_digit);
                            r_b       <= '0;
                            r_op      <= OP_NONE;
                            op_char   <= CH_NONE;
                            result    <= '0;
                            calc_done <= 1'b0;
                            input_val <= w_key;
                            r_state   <= S_A;
                        end
                    end
                    default: r_state <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl; results are checked by a scoreboard monitor on calc_done.
module tb_calc_ctrl;

    logic        clk_in;
    logic        sys_rst_n;
    logic        key_up, key_down, key_left, key_right, key_sel;
    logic [3:0]  cursor_x, cursor_y;
    logic [7:0]  input_val, op_char;
    logic [15:0] result;
    logic        calc_done, busy;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_q[$];
    int          tx = 0;
    int          ty = 0;
    logic        prev_done = 1'b0;

    calc_ctrl #(.OPERAND_W(8)) dut (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_sel   (key_sel),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .input_val (input_val),
        .op_char   (op_char),
        .result    (result),
        .calc_done (calc_done),
        .busy      (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each rising calc_done consumes one expected result.
    always @(negedge clk_in) begin
        if (calc_done && !prev_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(result), 32'hFFFF_FFFF);
            end else begin
                chk("result", 32'(result), exp_q.pop_front());
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        prev_done = calc_done;
    end

    // One cycle of key pulses, applied at the next rising edge; returns on the following negedge.
    task automatic step(input logic u, input logic d, input logic l, input logic r, input logic s);
        key_up = u; key_down = d; key_left = l; key_right = r; key_sel = s;
        @(negedge clk_in);
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_sel = 0;
        if (u)      ty = (ty + 3) % 4;
        else if (d) ty = (ty + 1) % 4;
        else if (l) tx = (tx + 3) % 4;
        else if (r) tx = (tx + 1) % 4;
    endtask

    function automatic void key_pos(input byte ch, output int r, output int c);
        case (ch)
            "1": begin r = 0; c = 0; end
            "2": begin r = 0; c = 1; end
            "3": begin r = 0; c = 2; end
            "+": begin r = 0; c = 3; end
            "4": begin r = 1; c = 0; end
            "5": begin r = 1; c = 1; end
            "6": begin r = 1; c = 2; end
            "-": begin r = 1; c = 3; end
            "7": begin r = 2; c = 0; end
            "8": begin r = 2; c = 1; end
            "9": begin r = 2; c = 2; end
            "*": begin r = 2; c = 3; end
            "C": begin r = 3; c = 0; end
            "0": begin r = 3; c = 1; end
            "=": begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end
        endcase
    endfunction

    // Shortest wrapped path to the key, then select it.
    task automatic press(input byte ch);
        int r, c, dy, dx;
        key_pos(ch, r, c);
        dy = (r - ty + 4) % 4;
        dx = (c - tx + 4) % 4;
        if (dy == 3) step(1, 0, 0, 0, 0);
        else repeat (dy) step(0, 1, 0, 0, 0);
        if (dx == 3) step(0, 0, 1, 0, 0);
        else repeat (dx) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!calc_done && n < max_cycles) begin
            @(negedge clk_in);
            n++;
        end
        chk("done_within_bound", 32'(calc_done), 1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_input_val"}, 32'(input_val), 0);
        chk({tag, "_op_char"},   32'(op_char), 0);
        chk({tag, "_result"},    32'(result), 0);
        chk({tag, "_calc_done"}, 32'(calc_done), 0);
        chk({tag, "_busy"},      32'(busy), 0);
    endtask

    initial begin
        int n;
        sys_rst_n = 1'b0;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_sel = 0;
        repeat (3) @(negedge clk_in);
        sys_rst_n = 1'b1;
        @(negedge clk_in);
        chk("rst_cursor_x", 32'(cursor_x), 0);
        chk("rst_cursor_y", 32'(cursor_y), 0);
        chk_cleared("rst");

        // Cursor wrap and direction priority
        repeat (5) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("wrap_cursor_x", 32'(cursor_x), 1);
        chk("wrap_cursor_y", 32'(cursor_y), 3);
        step(1, 0, 1, 0, 0);
        chk("prio_cursor_x", 32'(cursor_x), 1);
        chk("prio_cursor_y", 32'(cursor_y), 2);

        // 12 + 34
        press("1"); press("2"); press("+");
        chk("add_op_char", 32'(op_char), 32'h2B);
        press("3"); press("4");
        chk("add_input_val", 32'(input_val), 32'h34);
        exp_q.push_back(46);
        press("=");
        chk("add_busy_entry", 32'(busy), 1);
        chk("add_done_entry", 32'(calc_done), 0);
        @(negedge clk_in);
        chk("add_done_next", 32'(calc_done), 1);
        chk("add_busy_next", 32'(busy), 0);

        // 255 * 255 starting from S_DONE
        press("2");
        chk("new_calc_result", 32'(result), 0);
        chk("new_calc_done", 32'(calc_done), 0);
        press("5"); press("5"); press("*"); press("2"); press("5"); press("5");
        exp_q.push_back(65025);
        press("=");
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk_in);
        end
        chk("mul_busy_cycles", 32'(n), 8);
        chk("mul_done", 32'(calc_done), 1);

        // Digit in S_DONE restarts entry
        press("7");
        chk("restart_done", 32'(calc_done), 0);
        chk("restart_op_char", 32'(op_char), 0);
        chk("restart_result", 32'(result), 0);
        chk("restart_input_val", 32'(input_val), 32'h37);

        // 3 - 9 clamps to zero
        press("C"); press("3"); press("-"); press("9");
        exp_q.push_back(0);
        press("=");
        wait_done(5);

        // Overflowing digit is ignored: 25 + 1
        press("C"); press("2"); press("5"); press("6");
        chk("ovf_input_val", 32'(input_val), 32'h36);
        press("+"); press("1");
        exp_q.push_back(26);
        press("=");
        wait_done(5);

        // Abort a multiplication with C; "*" while busy is ignored
        press("2"); press("*"); press("3"); press("=");
        chk("abort_busy", 32'(busy), 1);
        press("*");
        chk("abort_op_kept", 32'(op_char), 32'h2A);
        chk("abort_still_busy", 32'(busy), 1);
        press("C");
        chk_cleared("abort");
        repeat (12) @(negedge clk_in);
        chk("abort_no_done", 32'(calc_done), 0);
        press("5"); press("+"); press("5");
        exp_q.push_back(10);
        press("=");
        wait_done(5);

        // Asynchronous reset in the middle of entry
        press("4"); press("+"); press("6");
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_cursor_x", 32'(cursor_x), 0);
        chk("mid_rst_cursor_y", 32'(cursor_y), 0);
        chk_cleared("mid_rst");
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        tx = 0; ty = 0;
        @(negedge clk_in);
        press("9"); press("*"); press("9");
        exp_q.push_back(81);
        press("=");
        wait_done(20);

        repeat (3) @(negedge clk_in);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
